// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a 5-stage in-order pipeline: stalls, flushes, operand
// forwarding, data-memory wait/timeout handling and stall/flush performance counters.
module pipeline_hazard_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic [4:0]  ex_rs,
  input  logic [4:0]  ex_rt,
  input  logic [4:0]  ex_rd,
  input  logic        ex_regwrite,
  input  logic        ex_memtoreg,
  input  logic [4:0]  mem_rd,
  input  logic        mem_regwrite,
  input  logic [4:0]  wb_rd,
  input  logic        wb_regwrite,
  input  logic        ex_branch_taken,
  input  logic        mem_req,
  input  logic        dmem_ready,
  input  logic        perf_clr,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt,
  output logic        mem_timeout
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    ERROR   = 2'd2
  } state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  state_e      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;
  logic        mem_timeout_q, mem_timeout_d;

  logic freeze;
  logic load_use;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      RUN: begin
        wait_cnt_d = 8'd0;
        if (mem_req && !dmem_ready) state_d = MEMWAIT;
      end
      MEMWAIT: begin
        if (dmem_ready) begin
          state_d    = RUN;
          wait_cnt_d = 8'd0;
        end else if (wait_cnt_q == 8'hFF) begin
          state_d = ERROR;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      ERROR:   state_d = ERROR;
      default: state_d = RUN;
    endcase
  end

  assign freeze   = (mem_req && !dmem_ready) || (state_q == ERROR);
  assign load_use = ex_regwrite && ex_memtoreg && (ex_rd != 5'd0) &&
                    ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

  // Priority: reset, then a frozen pipe, then a taken branch, then the load-use bubble.
  always_comb begin
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    idex_en    = 1'b0;
    exmem_en   = 1'b0;
    memwb_en   = 1'b0;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    if (rst_n && !freeze) begin
      pc_en    = 1'b1;
      ifid_en  = 1'b1;
      idex_en  = 1'b1;
      exmem_en = 1'b1;
      memwb_en = 1'b1;
      if (ex_branch_taken) begin
        flush_ifid = 1'b1;
        flush_idex = 1'b1;
      end else if (load_use) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        flush_idex = 1'b1;
      end
    end
  end

  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    if (mem_regwrite && (mem_rd != 5'd0) && (mem_rd == src))   return FWD_MEM;
    else if (wb_regwrite && (wb_rd != 5'd0) && (wb_rd == src)) return FWD_WB;
    else                                                       return FWD_RF;
  endfunction

  assign fwd_a = rst_n ? fwd_sel(ex_rs) : FWD_RF;
  assign fwd_b = rst_n ? fwd_sel(ex_rt) : FWD_RF;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (perf_clr) begin
      stall_cnt_d = 16'd0;
      flush_cnt_d = 16'd0;
    end else begin
      if (!pc_en && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
      if (flush_ifid && (flush_cnt_q != 16'hFFFF)) flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  // Sticky: once ERROR is reached only rst_n clears the flag.
  assign mem_timeout_d = mem_timeout_q || (state_d == ERROR);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      wait_cnt_q    <= 8'd0;
      stall_cnt_q   <= 16'd0;
      flush_cnt_q   <= 16'd0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;
  assign mem_timeout = mem_timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: stimulus pushes hand-computed
// expectations, a negedge monitor pops and compares them under a field mask.
module tb_pipeline_hazard_ctrl;

  logic        clk;
  logic        rst_n;
  logic [4:0]  id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic        id_uses_rt, ex_regwrite, ex_memtoreg, mem_regwrite, wb_regwrite;
  logic        ex_branch_taken, mem_req, dmem_ready, perf_clr;
  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en, flush_ifid, flush_idex;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_cnt, flush_cnt;
  logic        mem_timeout;

  pipeline_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .dmem_ready(dmem_ready),
    .perf_clr(perf_clr),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .mem_timeout(mem_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed vector: {en[4:0], flush[1:0], fwd_a, fwd_b, mem_timeout, stall_cnt, flush_cnt}
  typedef struct {
    string       name;
    logic [43:0] exp;
    logic [43:0] mask;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic push(input string name, input logic [43:0] e, input logic [43:0] m);
    exp_t x;
    x.name = name;
    x.exp  = e;
    x.mask = m;
    sbq.push_back(x);
  endtask

  task automatic exp_ctl(input string name, input logic [4:0] en, input logic [1:0] fl);
    push(name, {en, fl, 37'd0}, {7'h7F, 37'd0});
  endtask

  task automatic exp_fwd(input string name, input logic [1:0] a, input logic [1:0] b);
    push(name, {7'd0, a, b, 33'd0}, {7'd0, 4'hF, 33'd0});
  endtask

  task automatic exp_cnt(input string name, input logic to, input logic [15:0] sc,
                         input logic [15:0] fc);
    push(name, {11'd0, to, sc, fc}, {11'd0, 1'b1, 16'hFFFF, 16'hFFFF});
  endtask

  task automatic exp_all_zero(input string name);
    push(name, 44'd0, {44{1'b1}});
  endtask

  initial begin : monitor
    exp_t        e;
    logic [43:0] act;
    forever begin
      @(negedge clk);
      while (sbq.size() > 0) begin
        e   = sbq.pop_front();
        act = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, flush_ifid, flush_idex,
               fwd_a, fwd_b, mem_timeout, stall_cnt, flush_cnt};
        n_checks++;
        if ((act & e.mask) !== (e.exp & e.mask)) begin
          n_fail++;
          $display("FAIL %s: got %h required %h (mask %h) at %0t",
                   e.name, act & e.mask, e.exp & e.mask, e.mask, $time);
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
    ex_rs = 5'd0; ex_rt = 5'd0; ex_rd = 5'd0;
    ex_regwrite = 1'b0; ex_memtoreg = 1'b0;
    mem_rd = 5'd0; mem_regwrite = 1'b0; wb_rd = 5'd0; wb_regwrite = 1'b0;
    ex_branch_taken = 1'b0; mem_req = 1'b0; dmem_ready = 1'b0; perf_clr = 1'b0;
  endtask

  task automatic set_load_use();
    ex_rd = 5'd5; ex_regwrite = 1'b1; ex_memtoreg = 1'b1; id_rs = 5'd5;
  endtask

  initial begin : stimulus
    rst_n = 1'b0;
    drive_idle();
    tick();
    // Reset must mask an active branch and a forwarding match.
    ex_branch_taken = 1'b1; mem_regwrite = 1'b1; mem_rd = 5'd3; ex_rs = 5'd3;
    exp_all_zero("reset_outputs");
    tick();
    rst_n = 1'b1;
    drive_idle();
    exp_ctl("idle_ctl", 5'b11111, 2'b00);
    exp_cnt("idle_cnt", 1'b0, 16'd0, 16'd0);
    tick();

    // Forwarding
    mem_regwrite = 1'b1; wb_regwrite = 1'b1; mem_rd = 5'd3; wb_rd = 5'd3;
    ex_rs = 5'd3; ex_rt = 5'd0;
    exp_fwd("fwd_mem_prio", 2'b10, 2'b00);
    tick();
    mem_rd = 5'd0;
    exp_fwd("fwd_wb_memrd0", 2'b01, 2'b00);
    tick();
    mem_rd = 5'd7; ex_rt = 5'd7;
    exp_fwd("fwd_a_wb_b_mem", 2'b01, 2'b10);
    tick();
    mem_regwrite = 1'b0; wb_regwrite = 1'b0;
    exp_fwd("fwd_no_regwrite", 2'b00, 2'b00);
    tick();
    mem_regwrite = 1'b1; wb_regwrite = 1'b1; wb_rd = 5'd0; ex_rs = 5'd0;
    exp_fwd("fwd_rd0_ignored", 2'b00, 2'b10);
    tick();

    // Load-use bubble and its non-triggering boundaries
    drive_idle();
    set_load_use();
    exp_ctl("lu_rs", 5'b00111, 2'b01);
    tick();
    id_rs = 5'd1; id_rt = 5'd5; id_uses_rt = 1'b1;
    exp_ctl("lu_rt", 5'b00111, 2'b01);
    exp_cnt("lu_cnt1", 1'b0, 16'd1, 16'd0);
    tick();
    id_uses_rt = 1'b0;
    exp_ctl("lu_rt_unused", 5'b11111, 2'b00);
    tick();
    id_rs = 5'd5; ex_memtoreg = 1'b0;
    exp_ctl("lu_not_load", 5'b11111, 2'b00);
    tick();
    ex_memtoreg = 1'b1; ex_rd = 5'd0; id_rs = 5'd0;
    exp_ctl("lu_rd0", 5'b11111, 2'b00);
    tick();
    exp_cnt("lu_cnt2", 1'b0, 16'd2, 16'd0);

    // Branch overrides load-use
    drive_idle();
    set_load_use();
    ex_branch_taken = 1'b1;
    exp_ctl("br_over_lu", 5'b11111, 2'b11);
    tick();
    exp_cnt("br_cnt1", 1'b0, 16'd2, 16'd1);
    drive_idle();
    ex_branch_taken = 1'b1;
    exp_ctl("br_only", 5'b11111, 2'b11);
    tick();
    exp_cnt("br_cnt2", 1'b0, 16'd2, 16'd2);

    // Memory wait for 4 cycles: freeze beats branch, forwarding still live
    drive_idle();
    mem_req = 1'b1; ex_branch_taken = 1'b1;
    mem_regwrite = 1'b1; mem_rd = 5'd3; ex_rs = 5'd3;
    for (int i = 0; i < 4; i++) begin
      exp_ctl("mw_freeze", 5'b00000, 2'b00);
      exp_fwd("mw_fwd", 2'b10, 2'b00);
      tick();
    end
    dmem_ready = 1'b1; ex_branch_taken = 1'b0;
    exp_ctl("mw_ready", 5'b11111, 2'b00);
    exp_cnt("mw_cnt", 1'b0, 16'd6, 16'd2);
    tick();
    exp_cnt("mw_cnt_after", 1'b0, 16'd6, 16'd2);

    // Reset while in MEMWAIT
    drive_idle();
    mem_req = 1'b1;
    repeat (3) tick();
    exp_cnt("rm_cnt", 1'b0, 16'd9, 16'd2);
    tick();
    rst_n = 1'b0;
    mem_regwrite = 1'b1; mem_rd = 5'd3; ex_rs = 5'd3;
    exp_all_zero("rm_reset");
    tick();
    rst_n = 1'b1;
    drive_idle();
    tick();
    exp_ctl("rm_resume", 5'b11111, 2'b00);
    exp_cnt("rm_resume_cnt", 1'b0, 16'd0, 16'd0);
    tick();

    // Timeout: ERROR entered on the edge after the 256th MEMWAIT cycle
    mem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      tick();
      exp_ctl("to_freeze", 5'b00000, 2'b00);
      exp_cnt("to_state", (i >= 257), 16'(i), 16'd0);
    end
    mem_req = 1'b0; dmem_ready = 1'b1;
    exp_ctl("err_ready_ignored", 5'b00000, 2'b00);
    exp_cnt("err_sticky", 1'b1, 16'd300, 16'd0);
    tick();
    exp_cnt("err_sticky2", 1'b1, 16'd301, 16'd0);
    tick();
    rst_n = 1'b0;
    exp_all_zero("err_reset");
    tick();
    rst_n = 1'b1;
    drive_idle();
    tick();
    exp_ctl("err_resume", 5'b11111, 2'b00);
    exp_cnt("err_resume_cnt", 1'b0, 16'd0, 16'd0);
    tick();

    // Saturation and clear
    ex_branch_taken = 1'b1;
    tick();
    drive_idle();
    set_load_use();
    repeat (65535) tick();
    exp_cnt("sat_reach", 1'b0, 16'hFFFF, 16'd1);
    exp_ctl("sat_ctl", 5'b00111, 2'b01);
    repeat (5) tick();
    exp_cnt("sat_hold", 1'b0, 16'hFFFF, 16'd1);
    perf_clr = 1'b1;
    tick();
    exp_cnt("clr_prio", 1'b0, 16'd0, 16'd0);
    perf_clr = 1'b0;
    tick();
    exp_cnt("clr_then_inc", 1'b0, 16'd1, 16'd0);
    drive_idle();
    tick();
    exp_cnt("clr_idle", 1'b0, 16'd1, 16'd0);

    repeat (2) tick();
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset: clk and rst_n.
REQ-002 SHALL have port clk, input, 1 bit: rising-edge clock for all state.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have ports id_rs and id_rt, input, 5 bits each: source registers of the instruction in ID.
REQ-005 SHALL have port id_uses_rt, input, 1 bit: the ID instruction reads rt (R-type, beq, bne, sw).
REQ-006 SHALL have ports ex_rs and ex_rt, input, 5 bits each: source registers of the instruction in EX.
REQ-007 SHALL have ports ex_rd (input, 5 bits), ex_regwrite (input, 1 bit) and ex_memtoreg (input, 1 bit): destination and write controls of the EX instruction.
REQ-008 SHALL have ports mem_rd (input, 5 bits) and mem_regwrite (input, 1 bit), and wb_rd (input, 5 bits) and wb_regwrite (input, 1 bit): destination and write control of the MEM and WB instructions.
REQ-009 SHALL have port ex_branch_taken, input, 1 bit: a branch in EX resolved taken.
REQ-010 SHALL have ports mem_req (input, 1 bit), meaning lw/sw in MEM, and dmem_ready (input, 1 bit), meaning the data-memory access completes this cycle.
REQ-011 SHALL have port perf_clr, input, 1 bit: synchronous clear of the performance counters.
REQ-012 SHALL have ports pc_en, ifid_en, idex_en, exmem_en and memwb_en, output, 1 bit each: pipeline register enables.
REQ-013 SHALL have ports flush_ifid and flush_idex, output, 1 bit each: load a bubble into the register.
REQ-014 SHALL have ports fwd_a and fwd_b, output, 2 bits each: 00 = register file, 10 = EX/MEM result, 01 = MEM/WB result.
REQ-015 SHALL have ports stall_cnt and flush_cnt, output, 16 bits each: performance counters.
REQ-016 SHALL have port mem_timeout, output, 1 bit: sticky memory-timeout error.

Function
REQ-017 SHALL implement FSM states RUN, MEMWAIT and ERROR, plus an 8-bit wait counter wait_cnt.
REQ-018 SHALL transition RUN->MEMWAIT when mem_req=1 and dmem_ready=0.
REQ-019 SHALL transition MEMWAIT->RUN on dmem_ready=1, clearing wait_cnt.
REQ-020 SHALL, in MEMWAIT while dmem_ready=0, increment wait_cnt, and SHALL transition to ERROR when wait_cnt=255 and dmem_ready=0.
REQ-021 SHALL define freeze = (mem_req and not dmem_ready) in any state, or state=ERROR.
REQ-022 SHALL, while freeze=1, drive all five enables to 0 and both flushes to 0, with no instruction advancing.
REQ-023 SHALL define load_use = ex_regwrite and ex_memtoreg and ex_rd!=0 and (ex_rd==id_rs or (id_uses_rt and ex_rd==id_rt)).
REQ-024 SHALL, when not freeze and ex_branch_taken=1, drive flush_ifid=1, flush_idex=1 and all enables 1; branch priority overrides load_use.
REQ-025 SHALL, when not freeze, no taken branch and load_use=1, drive pc_en=0, ifid_en=0 and flush_idex=1, with the other enables 1; this is a single-cycle bubble.
REQ-026 SHALL otherwise drive all enables 1 and both flushes 0.
REQ-027 SHALL drive fwd_a=10 if mem_regwrite, mem_rd!=0 and mem_rd==ex_rs.
REQ-028 SHALL otherwise drive fwd_a=01 if wb_regwrite, wb_rd!=0 and wb_rd==ex_rs, else 00.
REQ-029 SHALL compute fwd_b identically using ex_rt, with MEM having priority over WB; forwarding is combinational and independent of freeze.
REQ-030 SHALL increment stall_cnt on each clock edge where pc_en=0, saturating at 16'hFFFF.
REQ-031 SHALL increment flush_cnt on each clock edge where flush_ifid=1, saturating at 16'hFFFF.
REQ-032 SHALL clear both counters to 0 when perf_clr=1, with clear taking priority over increment.
REQ-033 SHALL register mem_timeout: set on entry to ERROR, held until reset; ERROR exits only via rst_n.
REQ-034 SHALL keep enable, flush and fwd outputs combinational from state and inputs (zero latency); counters and mem_timeout are registered (one-cycle latency).

Reset
REQ-035 SHALL, on rst_n=0 (asynchronous), set state=RUN, wait_cnt=0, stall_cnt=0, flush_cnt=0 and mem_timeout=0.
REQ-036 SHALL, while rst_n=0, force all enables to 0, flushes to 0 and fwd_a=fwd_b=00.
REQ-037 SHALL, when reset is asserted mid-MEMWAIT or in ERROR, return to RUN with the counter cleared, and resume normal output one cycle after rst_n rises.

Verification
REQ-038 SHALL cover load-use: ex_rd=5, ex_regwrite=1, ex_memtoreg=1, id_rs=5 -> pc_en=0, ifid_en=0, flush_idex=1 for one cycle; stall_cnt increments by 1.
REQ-039 SHALL cover branch plus load-use together: ex_branch_taken=1 with a load-use condition -> flush_ifid=1, flush_idex=1, pc_en=1; flush_cnt increments by 1.
REQ-040 SHALL cover forwarding: mem_rd=wb_rd=3, both regwrite=1, ex_rs=3 -> fwd_a=10; the same with mem_rd=0 -> fwd_a=01; ex_rt=0 -> fwd_b=00.
REQ-041 SHALL cover a memory wait: mem_req=1, dmem_ready=0 for 4 cycles, then 1 -> all enables 0 for 4 cycles, state returns to RUN, stall_cnt increases by 4.
REQ-042 SHALL cover a memory timeout: dmem_ready held 0 for 300 cycles -> mem_timeout=1 after the 256th wait cycle, enables stay 0; dmem_ready=1 has no effect; rst_n pulse clears it.
REQ-043 SHALL cover counter saturation and clear: preload stall_cnt to 16'hFFFF via a long stall -> it holds at FFFF; perf_clr=1 together with a stall -> 0.
